// File: rtl/trng_top.sv
// Random-bit generator: four LFSR "oscillators" XOR-combined, sampled at a divided
// rate, screened by a repetition-count health test and debiased (von Neumann).
module trng_top #(
    parameter int unsigned SAMPLE_DIV = 4,
    parameter int unsigned REP_LIMIT  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic random_bit,
    output logic random_valid
);

    localparam logic [7:0] DivLast = 8'(SAMPLE_DIV - 1);
    localparam logic [7:0] RepLim  = 8'(REP_LIMIT);

    logic [12:0] s13_q, s13_d;
    logic [14:0] s15_q, s15_d;
    logic [16:0] s17_q, s17_d;
    logic [18:0] s19_q, s19_d;

    logic [7:0] div_q, div_d;
    logic       last_raw_q, last_raw_d;
    logic [7:0] rep_cnt_q, rep_cnt_d;
    logic       fail_q, fail_d;
    logic       has_first_q, has_first_d;
    logic       first_q, first_d;
    logic       random_bit_q, random_bit_d;
    logic       random_valid_q, random_valid_d;

    logic raw;
    logic strobe;

    // Free-running Fibonacci LFSRs; they ignore enable so entropy keeps evolving.
    always_comb begin
        s13_d = {s13_q[11:0], s13_q[12] ^ s13_q[11] ^ s13_q[10] ^ s13_q[7]};
        s15_d = {s15_q[13:0], s15_q[14] ^ s15_q[13]};
        s17_d = {s17_q[15:0], s17_q[16] ^ s17_q[13]};
        s19_d = {s19_q[17:0], s19_q[18] ^ s19_q[17] ^ s19_q[16] ^ s19_q[13]};
        raw   = s13_q[12] ^ s15_q[14] ^ s17_q[16] ^ s19_q[18];
    end

    // Sample-rate divider; held at zero while disabled so each run starts a fresh period.
    always_comb begin
        strobe = enable && (div_q == DivLast);
        div_d  = 8'd0;
        if (enable && (div_q != DivLast)) begin
            div_d = div_q + 8'd1;
        end
    end

    // Repetition-count health test with a sticky fail flag.
    always_comb begin
        last_raw_d = last_raw_q;
        rep_cnt_d  = rep_cnt_q;
        fail_d     = fail_q;
        if (strobe) begin
            if (raw == last_raw_q) begin
                rep_cnt_d = (rep_cnt_q == 8'hff) ? rep_cnt_q : rep_cnt_q + 8'd1;
            end else begin
                rep_cnt_d = 8'd1;
            end
            last_raw_d = raw;
            if (rep_cnt_d >= RepLim) begin
                fail_d = 1'b1;
            end
        end
    end

    // Von Neumann debiaser; fail_d gates the strobe that trips the health test too.
    always_comb begin
        has_first_d    = has_first_q;
        first_d        = first_q;
        random_bit_d   = random_bit_q;
        random_valid_d = 1'b0;
        if (!enable) begin
            has_first_d = 1'b0;
        end else if (strobe) begin
            if (!has_first_q) begin
                has_first_d = 1'b1;
                first_d     = raw;
            end else begin
                has_first_d = 1'b0;
                if ((raw != first_q) && !fail_d) begin
                    random_bit_d   = first_q;
                    random_valid_d = 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s13_q          <= '1;
            s15_q          <= '1;
            s17_q          <= '1;
            s19_q          <= '1;
            div_q          <= 8'd0;
            last_raw_q     <= 1'b0;
            rep_cnt_q      <= 8'd0;
            fail_q         <= 1'b0;
            has_first_q    <= 1'b0;
            first_q        <= 1'b0;
            random_bit_q   <= 1'b0;
            random_valid_q <= 1'b0;
        end else begin
            s13_q          <= s13_d;
            s15_q          <= s15_d;
            s17_q          <= s17_d;
            s19_q          <= s19_d;
            div_q          <= div_d;
            last_raw_q     <= last_raw_d;
            rep_cnt_q      <= rep_cnt_d;
            fail_q         <= fail_d;
            has_first_q    <= has_first_d;
            first_q        <= first_d;
            random_bit_q   <= random_bit_d;
            random_valid_q <= random_valid_d;
        end
    end

    assign random_bit   = random_bit_q;
    assign random_valid = random_valid_q;

endmodule

// File: tb/tb_trng_top.sv
// Bench for trng_top: reference model of the LFSR/XOR/health/debias chain, scoreboard of
// expected bits, table of idle/reset vectors and hand-written multi-cycle sequences.
module tb_trng_top;

    localparam int Div = 4;

    typedef struct {
        logic [12:0] s13;
        logic [14:0] s15;
        logic [16:0] s17;
        logic [18:0] s19;
        int          div;
        logic        last_raw;
        int          rep;
        logic        fail;
        logic        hf;
        logic        first;
        logic        rbit;
        logic        rvalid;
    } mstate_t;

    typedef struct {
        logic rst;
        logic en;
        int   cycles;
        logic exp_bit;
        logic exp_valid;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic bit1, val1, bit2, val2;

    int checks = 0;
    int errors = 0;

    mstate_t m1, m2;
    logic    exp_q[$];
    int      ecnt;
    int      last_v = 0;
    int      vcount = 0, ones = 0, v2count = 0, mv2count = 0;

    trng_top #(.SAMPLE_DIV(4), .REP_LIMIT(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .random_bit(bit1), .random_valid(val1)
    );

    trng_top #(.SAMPLE_DIV(4), .REP_LIMIT(2)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .random_bit(bit2), .random_valid(val2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic mstate_t mreset();
        mstate_t m;
        m.s13 = '1; m.s15 = '1; m.s17 = '1; m.s19 = '1;
        m.div = 0; m.last_raw = 1'b0; m.rep = 0; m.fail = 1'b0;
        m.hf = 1'b0; m.first = 1'b0; m.rbit = 1'b0; m.rvalid = 1'b0;
        return m;
    endfunction

    function automatic mstate_t mstep(input mstate_t m, input logic en, input int lim);
        mstate_t n;
        logic    raw;
        n   = m;
        raw = m.s13[12] ^ m.s15[14] ^ m.s17[16] ^ m.s19[18];
        n.s13 = {m.s13[11:0], m.s13[12] ^ m.s13[11] ^ m.s13[10] ^ m.s13[7]};
        n.s15 = {m.s15[13:0], m.s15[14] ^ m.s15[13]};
        n.s17 = {m.s17[15:0], m.s17[16] ^ m.s17[13]};
        n.s19 = {m.s19[17:0], m.s19[18] ^ m.s19[17] ^ m.s19[16] ^ m.s19[13]};
        n.rvalid = 1'b0;
        if (!en) begin
            n.div = 0;
            n.hf  = 1'b0;
        end else begin
            n.div = (m.div + 1) % Div;
            if (m.div == Div - 1) begin
                if (raw == m.last_raw) n.rep = (m.rep >= 255) ? 255 : m.rep + 1;
                else n.rep = 1;
                n.last_raw = raw;
                if (n.rep >= lim) n.fail = 1'b1;
                if (!m.hf) begin
                    n.hf    = 1'b1;
                    n.first = raw;
                end else begin
                    n.hf = 1'b0;
                    if (raw != m.first && !n.fail) begin
                        n.rbit   = m.first;
                        n.rvalid = 1'b1;
                    end
                end
            end
        end
        return n;
    endfunction

    // Reference models advance in lockstep with the DUTs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1 <= mreset();
            m2 <= mreset();
        end else begin
            m1 <= mstep(m1, enable, 16);
            m2 <= mstep(m2, enable, 2);
        end
    end

    // Enabled-edge count since enable last rose.
    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else if (enable) ecnt <= ecnt + 1;
        else ecnt <= 0;
    end

    // Per-cycle checker and scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (m1.rvalid) exp_q.push_back(m1.rbit);
            check("valid1_timing", int'(val1), int'(m1.rvalid));
            check("valid2_timing", int'(val2), int'(m2.rvalid));
            if (m2.rvalid) mv2count++;
            if (val2 === 1'b1) begin
                v2count++;
                if (m2.rvalid) check("bit2", int'(bit2), int'(m2.rbit));
            end
            if (ecnt == 0) last_v <= 0;
            if (val1 === 1'b1) begin
                vcount++;
                if (bit1 === 1'b1) ones++;
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 1, 0);
                end else begin
                    check("bit1", int'(bit1), int'(exp_q.pop_front()));
                end
                if (ecnt != 0) begin
                    check("spacing", int'((ecnt - last_v) >= 2 * Div &&
                                          ((ecnt - last_v) % Div) == 0), 1);
                    last_v <= ecnt;
                end
            end
        end
    end

    vec_t vecs[3];
    int   v_start, o_start, v2_start, mv2_start;
    logic f2_start;
    bit   found;

    initial begin
        vecs[0] = '{rst: 1'b1, en: 1'b0, cycles: 5,   exp_bit: 1'b0, exp_valid: 1'b0};
        vecs[1] = '{rst: 1'b0, en: 1'b0, cycles: 100, exp_bit: 1'b0, exp_valid: 1'b0};
        vecs[2] = '{rst: 1'b0, en: 1'b1, cycles: 7,   exp_bit: 1'b0, exp_valid: 1'b0};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rst    = vecs[i].rst;
            enable = vecs[i].en;
            for (int c = 0; c < vecs[i].cycles; c++) begin
                @(negedge clk);
                check($sformatf("vec%0d_bit", i), int'(bit1), int'(vecs[i].exp_bit));
                check($sformatf("vec%0d_valid", i), int'(val1), int'(vecs[i].exp_valid));
            end
        end

        // Long enabled run: acceptance rate and bit balance.
        v_start  = vcount;
        o_start  = ones;
        v2_start = v2count;
        f2_start = m2.fail;
        repeat (10000) @(negedge clk);
        check("valid_count_min", int'(vcount - v_start >= 600), 1);
        check("valid_count_max", int'(vcount - v_start <= 1250), 1);
        check("ones_low", int'((ones - o_start) * 100 >= 40 * (vcount - v_start)), 1);
        check("ones_high", int'((ones - o_start) * 100 <= 60 * (vcount - v_start)), 1);
        check("model_fail_default", int'(m1.fail), 0);
        check("rep2_failed", int'(m2.fail), 1);
        if (f2_start) check("rep2_silent", v2count - v2_start, 0);

        // Drop enable right after the first strobe of a pair.
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (m1.hf && m1.div == 0) found = 1'b1;
        end
        check("half_pair_found", int'(found), 1);
        enable = 1'b0;
        @(negedge clk);
        check("half_pair_dropped", int'(m1.hf), 0);
        enable = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            if (val1 === 1'b1) begin
                found = 1'b1;
                check("reenable_latency", int'(ecnt >= 2 * Div), 1);
            end
        end
        check("valid_after_reenable", int'(found), 1);

        // Mid-cycle asynchronous reset while random_bit is 1.
        found = 1'b0;
        for (int c = 0; c < 1000 && !found; c++) begin
            @(negedge clk);
            if (bit1 === 1'b1) found = 1'b1;
        end
        check("bit_one_seen", int'(found), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_bit", int'(bit1), 0);
        check("async_rst_valid", int'(val1), 0);
        enable = 1'b0;
        #1 rst = 1'b0;
        check("rst_clears_model_fail", int'(m2.fail), 0);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        v2_start  = v2count;
        mv2_start = mv2count;
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            if (val1 === 1'b1) found = 1'b1;
        end
        check("resume_after_rst", int'(found), 1);
        repeat (300) @(negedge clk);
        check("rep2_resume_count", v2count - v2_start, mv2count - mv2_start);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
